ioctl_upload_reader: RTL and testbench
======================================

Name: ioctl_upload_reader

Overview:
- Responder for the hps_io upload (save) direction: the HPS reads a core-side byte RAM (NVRAM or hiscore area) through 16-bit ioctl words.
- This is the reverse of the ROM/DIP download path.
- Sits between hps_io and a dedicated read port of the core's 8-bit RAM.
- Fetches two bytes per word, packs them, and holds ioctl_wait while the fetch is in progress.

Parameters:
- AW, 12, byte address width of the core RAM read port.
- SIZE, 4096, number of bytes exposed; must be even and ≤ 2^AW.
- RAM_LATENCY, 1, cycles from ram_addr valid to ram_dout valid (1..3).
- UPLOAD_INDEX, 8'd4, ioctl_index value this block answers to.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- ioctl_upload  in  1  upload session active (level).
- ioctl_index  in  8  selects the target; only UPLOAD_INDEX is served.
- ioctl_rd  in  1  one-cycle read strobe for the word at ioctl_addr.
- ioctl_addr  in  27  byte address, even, advances by 2 per word.
- ioctl_din  out  16  word returned as {byte[a+1], byte[a]}.
- ioctl_wait  out  1  high while a fetch is outstanding.
- ram_addr  out  AW  core RAM read address.
- ram_rd  out  1  read enable for the core RAM port.
- ram_dout  in  8  core RAM read data.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Interface: one clock, clk_sys; reset_n is synchronous and active-low.
- Reset values: ioctl_din=16'h0000, ioctl_wait=0, ram_addr=0, ram_rd=0, busy=0, FSM=IDLE.
- Active = ioctl_upload && ioctl_index==UPLOAD_INDEX. Strobes with active=0 are ignored and no output changes.
- FSM states: IDLE, RD_LO, WT_LO, RD_HI, WT_HI.
- IDLE: on ioctl_rd && active && ioctl_addr < SIZE:
  - latch base = ioctl_addr[AW-1:0] & ~1;
  - next cycle: ioctl_wait=1, go to RD_LO.
- IDLE, out of range: on ioctl_rd && active && ioctl_addr ≥ SIZE:
  - ioctl_din <= 16'hFFFF the next cycle;
  - ioctl_wait stays 0; stay in IDLE.
- RD_LO: ram_addr=base, ram_rd=1 for one cycle, go to WT_LO.
- WT_LO: count RAM_LATENCY-1 further cycles; on the cycle ram_dout is valid, latch lo byte, go to RD_HI.
- RD_HI / WT_HI: same sequence with ram_addr=base+1.
- Completion: on the cycle the hi byte is valid, ioctl_din <= {ram_dout, lo}, ioctl_wait <= 0, go to IDLE.
- Latency with RAM_LATENCY=1: strobe at cycle T; ioctl_wait high T+1..T+4; ioctl_din valid and ioctl_wait low at T+5. In general this is 3+2*RAM_LATENCY cycles after the strobe.
- ioctl_din holds its value until the next completed read.
- ioctl_rd while busy: ignored. The current fetch completes unchanged; the strobe is not queued.
- Abort: ioctl_upload falls, or ioctl_index changes, mid-fetch.
  - Next cycle: FSM=IDLE, ioctl_wait=0, ram_rd=0.
  - ioctl_din keeps its old value.
- Reset asserted mid-fetch: all outputs take their reset values on the next edge.
- base+1 never wraps, because SIZE is even and base < SIZE.
- busy = (state != IDLE).

Optional Feature:
- Macro: UPLOAD_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) is accumulated over every byte returned since ioctl_upload rose; it is cleared on the rising edge of ioctl_upload.
  - A read at ioctl_addr==SIZE returns {8'hA5, ~sum} with no RAM access and ioctl_wait kept 0. That word is the save-integrity trailer.
  - Addresses > SIZE return 16'hFFFF.
- Undefined: no accumulator; every address ≥ SIZE returns 16'hFFFF.

Decomposition:
- Package ioctl_pkg:
  - typedef for the FSM state enum;
  - localparams OOR_WORD=16'hFFFF and CSUM_TAG=8'hA5;
  - the ioctl index constants shared with the download path (0 = ROM, 254 = DIP, 4 = NVRAM).
- One natural sub-module: ioctl_lat_counter, a small down-counter giving the RAM_LATENCY wait. It is reused for both byte phases.

Test Plan:
- Preload RAM[0]=8'h34, RAM[1]=8'h12; upload active, index 4; ioctl_rd at addr 0 -> wait high 4 cycles, then ioctl_din=16'h1234 at T+5 and wait low.
- Back-to-back reads at addr 2, 4, 6 (RAM = 00..07), each issued after wait falls -> words 16'h0302, 16'h0504, 16'h0706; ram_addr sequence 2,3,4,5,6,7.
- ioctl_rd at addr 4096, SIZE=4096, no macro -> ioctl_din=16'hFFFF next cycle, ioctl_wait never high, ram_rd never high.
- ioctl_rd with ioctl_index=0 -> no ram_rd, ioctl_wait stays 0, ioctl_din unchanged.
- ioctl_upload dropped at T+2 of a fetch -> ioctl_wait=0 at T+3, FSM idle. The next valid read returns correct data.
- UPLOAD_CHECKSUM_EN, SIZE=4, RAM=01,02,03,04; read words 0, 2, then 4 -> third word is 16'hA5F5 (sum 8'h0A, inverted).

Source files
------------

// File: rtl/ioctl_pkg.sv
`default_nettype none
// ============================================================================
// ioctl_pkg : shared ioctl index constants, upload FSM state type and
//             upload reply words.
// Rev 1.0
// ============================================================================
package ioctl_pkg;

  // ioctl_index values shared with the download path
  localparam logic [7:0] IDX_ROM   = 8'd0;
  localparam logic [7:0] IDX_DIP   = 8'd254;
  localparam logic [7:0] IDX_NVRAM = 8'd4;

  localparam logic [15:0] OOR_WORD = 16'hFFFF;
  localparam logic [7:0]  CSUM_TAG = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_WT_LO = 3'd2,
    ST_RD_HI = 3'd3,
    ST_WT_HI = 3'd4
  } upl_state_t;

  // Save-integrity trailer: tag byte on top, inverted running sum below
  function automatic logic [15:0] csum_word(input logic [7:0] sum);
    return {CSUM_TAG, ~sum};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ioctl_lat_counter.sv
`default_nettype none
// ============================================================================
// ioctl_lat_counter : down-counter covering the RAM read latency of one
//                     byte phase; done is high on the cycle read data is valid.
// Rev 1.0
// ============================================================================
module ioctl_lat_counter #(
  parameter int LATENCY = 1
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic load,
  output logic done
);

  localparam logic [1:0] c_init = 2'(LATENCY - 1);

  logic [1:0] r_cnt;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_cnt <= 2'd0;
    end else if (load) begin
      r_cnt <= c_init;
    end else if (r_cnt != 2'd0) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  assign done = (r_cnt == 2'd0);

endmodule
`default_nettype wire

// File: rtl/ioctl_upload_reader.sv
`default_nettype none
// ============================================================================
// ioctl_upload_reader : answers hps_io upload reads by fetching two bytes from
//                       the core RAM read port and packing them into a word.
// Optional: UPLOAD_CHECKSUM_EN adds a checksum trailer word at ioctl_addr==SIZE.
// Rev 1.0
// ============================================================================
module ioctl_upload_reader
  import ioctl_pkg::*;
#(
  parameter int         AW           = 12,
  parameter int         SIZE         = 4096,
  parameter int         RAM_LATENCY  = 1,
  parameter logic [7:0] UPLOAD_INDEX = IDX_NVRAM
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [26:0]   ioctl_addr,
  output logic [15:0]   ioctl_din,
  output logic          ioctl_wait,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_dout,
  output logic          busy
);

  localparam logic [26:0] c_size = 27'(SIZE);

  upl_state_t    r_state;
  upl_state_t    w_state_nxt;
  // Word index of the fetch; the byte base is always even
  logic [AW-2:0] r_word;
  logic [AW-2:0] w_word_nxt;
  logic [7:0]    r_lo;
  logic [7:0]    w_lo_nxt;
  logic [15:0]   w_din_nxt;
  logic [15:0]   w_oor_word;
  logic [AW-1:0] w_ram_addr_nxt;
  logic          w_wait_nxt;
  logic          w_ram_rd_nxt;
  logic          w_active;
  logic          w_in_range;
  logic          w_lat_load;
  logic          w_lat_done;

  assign w_active   = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign w_in_range = (ioctl_addr < c_size);
  assign busy       = (r_state != ST_IDLE);

  ioctl_lat_counter #(
    .LATENCY (RAM_LATENCY)
  ) u_lat (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .load    (w_lat_load),
    .done    (w_lat_done)
  );

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_upload_d;
  logic       w_fetch_done;

  assign w_fetch_done = (r_state == ST_WT_HI) && w_active && w_lat_done;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_sum      <= 8'd0;
      r_upload_d <= 1'b0;
    end else begin
      r_upload_d <= ioctl_upload;
      if (ioctl_upload && !r_upload_d) begin
        r_sum <= 8'd0;
      end else if (w_fetch_done) begin
        r_sum <= r_sum + r_lo + ram_dout;
      end
    end
  end

  assign w_oor_word = (ioctl_addr == c_size) ? csum_word(r_sum) : OOR_WORD;
`else
  assign w_oor_word = OOR_WORD;
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_word     <= '0;
      r_lo       <= 8'd0;
      ioctl_din  <= 16'h0000;
      ioctl_wait <= 1'b0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_word     <= w_word_nxt;
      r_lo       <= w_lo_nxt;
      ioctl_din  <= w_din_nxt;
      ioctl_wait <= w_wait_nxt;
      ram_addr   <= w_ram_addr_nxt;
      ram_rd     <= w_ram_rd_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_word_nxt     = r_word;
    w_lo_nxt       = r_lo;
    w_din_nxt      = ioctl_din;
    w_wait_nxt     = ioctl_wait;
    w_ram_addr_nxt = ram_addr;
    w_ram_rd_nxt   = 1'b0;
    w_lat_load     = 1'b0;

    // Losing the session or the index mid-fetch drops the word silently
    if ((r_state != ST_IDLE) && !w_active) begin
      w_state_nxt = ST_IDLE;
      w_wait_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ioctl_rd && w_active) begin
            if (w_in_range) begin
              w_word_nxt     = ioctl_addr[AW-1:1];
              w_ram_addr_nxt = {ioctl_addr[AW-1:1], 1'b0};
              w_ram_rd_nxt   = 1'b1;
              w_wait_nxt     = 1'b1;
              w_state_nxt    = ST_RD_LO;
            end else begin
              w_din_nxt = w_oor_word;
            end
          end
        end
        ST_RD_LO: begin
          w_lat_load  = 1'b1;
          w_state_nxt = ST_WT_LO;
        end
        ST_WT_LO: begin
          if (w_lat_done) begin
            w_lo_nxt       = ram_dout;
            w_ram_addr_nxt = {r_word, 1'b1};
            w_ram_rd_nxt   = 1'b1;
            w_state_nxt    = ST_RD_HI;
          end
        end
        ST_RD_HI: begin
          w_lat_load  = 1'b1;
          w_state_nxt = ST_WT_HI;
        end
        ST_WT_HI: begin
          if (w_lat_done) begin
            w_din_nxt   = {ram_dout, r_lo};
            w_wait_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ioctl_upload_reader.sv
`default_nettype none
// Bench for ioctl_upload_reader: spec-level model with per-cycle compare
// plus directed reads with literal expectations.
module tb_ioctl_upload_reader;

  localparam int AW   = 12;
  localparam int SIZE = 4096;
  localparam int LAT  = 1;

  logic          clk_sys      = 1'b0;
  logic          reset_n      = 1'b0;
  logic          ioctl_upload = 1'b0;
  logic [7:0]    ioctl_index  = 8'd4;
  logic          ioctl_rd     = 1'b0;
  logic [26:0]   ioctl_addr   = '0;
  logic [15:0]   ioctl_din;
  logic          ioctl_wait;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_dout;
  logic          busy;

  always #5 clk_sys = ~clk_sys;

  ioctl_upload_reader #(
    .AW           (AW),
    .SIZE         (SIZE),
    .RAM_LATENCY  (LAT),
    .UPLOAD_INDEX (8'd4)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .ram_addr     (ram_addr),
    .ram_rd       (ram_rd),
    .ram_dout     (ram_dout),
    .busy         (busy)
  );

  // Core RAM with LAT cycles from address to data
  logic [7:0] mem  [SIZE];
  logic [7:0] pipe [LAT];
  always @(posedge clk_sys) begin
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_dout = pipe[LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted in-range strobe keeps wait high for 2+2*LAT cycles,
  // reads RAM at cycle 1 (base) and 2+LAT (base+1), word appears at 3+2*LAT.
  logic [15:0] m_din  = 16'h0000;
  bit          m_busy = 1'b0;
  int          m_k    = 0;
  int          m_base = 0;
  logic [7:0]  m_sum  = 8'h00;
  bit          m_up_d = 1'b0;

  always @(posedge clk_sys) begin
    bit act;
    act = ioctl_upload && (ioctl_index == 8'd4);
    if (!reset_n) begin
      m_din = 16'h0000; m_busy = 1'b0; m_k = 0; m_sum = 8'h00; m_up_d = 1'b0;
    end else begin
      if (ioctl_upload && !m_up_d) m_sum = 8'h00;
      if (m_busy) begin
        if (!act) m_busy = 1'b0;
        else begin
          m_k++;
          if (m_k == 3 + 2*LAT) begin
            m_din  = {mem[m_base+1], mem[m_base]};
            m_sum  = m_sum + mem[m_base] + mem[m_base+1];
            m_busy = 1'b0;
          end
        end
      end else if (ioctl_rd && act) begin
        if (ioctl_addr < SIZE) begin
          m_busy = 1'b1;
          m_k    = 1;
          m_base = int'(ioctl_addr) & ~1;
        end
`ifdef UPLOAD_CHECKSUM_EN
        else if (ioctl_addr == SIZE) m_din = {8'hA5, ~m_sum};
`endif
        else m_din = 16'hFFFF;
      end
      m_up_d = ioctl_upload;
    end
  end

  bit            chk_en = 1'b0;
  logic [AW-1:0] addr_log [$];

  always @(negedge clk_sys) begin
    if (chk_en) begin
      bit            exp_rd;
      logic [AW-1:0] exp_addr;
      exp_rd   = m_busy && (m_k == 1 || m_k == 2 + LAT);
      exp_addr = AW'((m_k == 1) ? m_base : m_base + 1);
      check("cyc_din",  ioctl_din,  m_din);
      check("cyc_wait", ioctl_wait, m_busy);
      check("cyc_busy", busy,       m_busy);
      check("cyc_rd",   ram_rd,     exp_rd);
      if (exp_rd) check("cyc_addr", ram_addr, exp_addr);
      if (ram_rd) addr_log.push_back(ram_addr);
    end
  end

  task automatic strobe(input logic [26:0] a);
    @(negedge clk_sys); #1;
    ioctl_rd = 1'b1; ioctl_addr = a;
    @(negedge clk_sys); #1;
    ioctl_rd = 1'b0;
  endtask

  // Returns number of cycles ioctl_wait was seen high after the strobe
  task automatic read_word(input logic [26:0] a, output int n);
    strobe(a);
    n = 0;
    while (ioctl_wait && n < 40) begin
      n++;
      @(negedge clk_sys); #1;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL read_timeout: wait still %0b after %0d cycles, required 0", ioctl_wait, n);
    end
  endtask

  initial begin
    int n;
    int base_log;
    int exp_a [6] = '{2, 3, 4, 5, 6, 7};

    for (int i = 0; i < SIZE; i++) mem[i] = i[7:0];
    mem[0] = 8'h34; mem[1] = 8'h12;
    mem[4094] = 8'hC3; mem[4095] = 8'h3C;

    reset_n = 1'b0; ioctl_upload = 1'b1; ioctl_index = 8'd4;
    repeat (3) @(negedge clk_sys);
    #1;
    check("rst_din",  ioctl_din,  16'h0000);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_busy", busy,       1'b0);
    check("rst_rd",   ram_rd,     1'b0);
    check("rst_addr", ram_addr,   12'h000);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // First word: four wait cycles, then packed bytes
    read_word(27'd0, n);
    check("t1_wait_cycles", n, 4);
    check("t1_din", ioctl_din, 16'h1234);
    check("t1_model", m_din, 16'h1234);

    // Back-to-back words and RAM address sequence
    base_log = addr_log.size();
    read_word(27'd2, n); check("t2_din2", ioctl_din, 16'h0302);
    read_word(27'd4, n); check("t2_din4", ioctl_din, 16'h0504);
    read_word(27'd6, n); check("t2_din6", ioctl_din, 16'h0706);
    check("t2_log_len", addr_log.size() - base_log, 6);
    for (int i = 0; i < 6; i++) check("t2_ram_addr", addr_log[base_log + i], exp_a[i]);

    // Out of range: immediate all-ones word, no RAM access
    base_log = addr_log.size();
`ifdef UPLOAD_CHECKSUM_EN
    read_word(27'd4097, n);
`else
    read_word(27'd4096, n);
`endif
    check("t3_wait_cycles", n, 0);
    check("t3_din", ioctl_din, 16'hFFFF);
    check("t3_no_rd", addr_log.size() - base_log, 0);

    // Foreign index ignored
    ioctl_index = 8'd0;
    read_word(27'd2, n);
    check("t4_wait_cycles", n, 0);
    check("t4_din", ioctl_din, 16'hFFFF);
    check("t4_no_rd", addr_log.size() - base_log, 0);
    ioctl_index = 8'd4;

    // Abort by dropping ioctl_upload at T+2
    strobe(27'd0);
    check("t5_wait_T1", ioctl_wait, 1'b1);
    @(negedge clk_sys); #1;
    ioctl_upload = 1'b0;
    @(negedge clk_sys); #1;
    check("t5_wait_T3", ioctl_wait, 1'b0);
    check("t5_busy_T3", busy, 1'b0);
    check("t5_din_T3", ioctl_din, 16'hFFFF);
    ioctl_upload = 1'b1;
    read_word(27'd4094, n);
    check("t5_last_word", ioctl_din, 16'h3CC3);

`ifdef UPLOAD_CHECKSUM_EN
    // Checksum trailer after a fresh session
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_sys);
    #1;
    ioctl_upload = 1'b1;
    read_word(27'd0, n); check("t6_w0", ioctl_din, 16'h0201);
    read_word(27'd2, n); check("t6_w2", ioctl_din, 16'h0403);
    read_word(27'd4096, n);
    check("t6_trailer_wait", n, 0);
    check("t6_trailer", ioctl_din, 16'hA5F5);
`endif

    // Reset in the middle of a fetch
    strobe(27'd2);
    @(negedge clk_sys); #1;
    reset_n = 1'b0;
    @(negedge clk_sys); #1;
    check("t7_din",  ioctl_din,  16'h0000);
    check("t7_wait", ioctl_wait, 1'b0);
    check("t7_busy", busy,       1'b0);
    check("t7_rd",   ram_rd,     1'b0);
    check("t7_addr", ram_addr,   12'h000);
    reset_n = 1'b1;
    read_word(27'd6, n);
    check("t7_after", ioctl_din, 16'h0706);

    repeat (2) @(negedge clk_sys);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
